// File: rtl/spi_ram_if.sv
// Word stream between the SPI slave and the command RAM.
// master = SPI slave side, slave = RAM controller side.
interface spi_ram_if;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       cmd_err;

  modport master (
    output rx_data, rx_valid,
    input  tx_data, tx_valid, busy, cmd_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output tx_data, tx_valid, busy, cmd_err
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind the SPI slave.
// Executes address/data writes and reads from 10-bit rx words.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input logic       clk,
  input logic       rst_n,
  spi_ram_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_PEND = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  localparam logic [ADDR_SIZE-1:0] ONE = ADDR_SIZE'(1);

  logic [7:0]           mem [MEM_DEPTH];
  logic [1:0]           state;
  logic                 rxv_d;
  logic                 drop_q;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [7:0]           rd_word;

  logic                 accept;
  logic                 pend;
  logic                 wr_en;
  logic                 rd_en;
  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] pl;

  assign accept = bus.rx_valid & ~rxv_d;
  assign pend   = (state == RD_PEND);
  assign cmd    = bus.rx_data[9:8];
  assign pl     = bus.rx_data[ADDR_SIZE-1:0];
  assign wr_en  = accept & ~pend & (cmd == WR_DATA);
  assign rd_en  = accept & ~pend & (cmd == RD_DATA);

  assign bus.busy = pend;

  // RAM array is deliberately unreset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= bus.rx_data[7:0];
    if (rd_en)
      rd_word <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rxv_d        <= 1'b1;
      drop_q       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.tx_data  <= 8'h00;
      bus.tx_valid <= 1'b0;
      bus.cmd_err  <= 1'b0;
    end else begin
      rxv_d       <= bus.rx_valid;
      drop_q      <= accept & pend;
      bus.cmd_err <= drop_q;
      if (pend) begin
        bus.tx_data  <= rd_word;
        bus.tx_valid <= 1'b1;
        state        <= RESP;
        if (AUTO_INC != 0)
          rd_ptr <= rd_ptr + ONE;
      end else if (accept) begin
        bus.tx_valid <= 1'b0;
        state        <= (cmd == RD_DATA) ? RD_PEND : IDLE;
        unique case (1'b1)
          (cmd == WR_ADDR): wr_ptr <= pl;
          (cmd == WR_DATA): begin
            if (AUTO_INC != 0)
              wr_ptr <= wr_ptr + ONE;
          end
          (cmd == RD_ADDR): rd_ptr <= pl;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl with AUTO_INC enabled.
// Read data is queued at stimulus time and matched at tx_valid rise.
module tb_spi_ram_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;
  logic [7:0] sb [$];
  logic txv_q = 1'b0;

  spi_ram_if bus();

  spi_ram_ctrl #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8),
    .AUTO_INC (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.tx_valid && !txv_q) begin
      if (sb.size() == 0)
        check("sb_underflow", 32'(sb.size()), 32'd1);
      else
        check("tx_data", {24'h0, bus.tx_data}, {24'h0, sb.pop_front()});
    end
    txv_q = bus.tx_valid;
  end

  task automatic rise(input logic [9:0] w);
    @(posedge clk); #1 bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    bus.rx_data  = w;
    bus.rx_valid = 1'b1;
  endtask

  task automatic wr(input logic [9:0] w);
    rise(w);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] exp);
    sb.push_back(exp);
    rise(10'h300);
    @(posedge clk); #1;
    check("pend_busy", 32'(bus.busy), 32'd1);
    check("pend_txv", 32'(bus.tx_valid), 32'd0);
    @(posedge clk); #1;
    check("resp_txv", 32'(bus.tx_valid), 32'd1);
    check("resp_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 check("resp_hold", 32'(bus.tx_valid), 32'd1);
  endtask

  task automatic rd_drop(input logic [7:0] exp,
                         input logic [9:0] w,
                         input logic [7:0] rp);
    sb.push_back(exp);
    rise(10'h300);
    @(posedge clk); #1;
    check("drop_busy", 32'(bus.busy), 32'd1);
    force dut.rxv_d = 1'b0;
    bus.rx_data = w;
    @(posedge clk); #1;
    release dut.rxv_d;
    bus.rx_valid = 1'b0;
    check("drop_txv", 32'(bus.tx_valid), 32'd1);
    check("drop_err_early", 32'(bus.cmd_err), 32'd0);
    @(posedge clk); #1;
    check("drop_err", 32'(bus.cmd_err), 32'd1);
    check("drop_txd", 32'(bus.tx_data), 32'(exp));
    check("drop_rdptr", 32'(dut.rd_ptr), 32'(rp));
    @(posedge clk); #1;
    check("drop_err_pulse", 32'(bus.cmd_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 10'h000;
    #1 rst_n = 1'b0;
    #1;
    check("rst_txv", 32'(bus.tx_valid), 32'd0);
    check("rst_txd", 32'(bus.tx_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.cmd_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    wr(10'h012);
    wr(10'h1A5);
    wr(10'h15A);
    wr(10'h212);
    rd(8'hA5);

    wr(10'h212);
    check("resp_exit_rd", 32'(bus.tx_valid), 32'd0);
    rd_drop(8'hA5, 10'h250, 8'h13);
    rd(8'h5A);

    wr(10'h040);
    rise(10'h13C);
    repeat (12) @(posedge clk);
    #1;
    check("level_wrptr", 32'(dut.wr_ptr), 32'h41);
    wr(10'h13D);
    wr(10'h240);
    rd(8'h3C);
    rd(8'h3D);

    wr(10'h0FF);
    wr(10'h111);
    wr(10'h122);
    check("wrap_wrptr", 32'(dut.wr_ptr), 32'h01);
    wr(10'h2FF);
    rd(8'h11);
    rd(8'h22);

    rise(10'h005);
    @(posedge clk); #1;
    check("exit_txv", 32'(bus.tx_valid), 32'd0);
    check("exit_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("exit_idle", 32'(dut.state), 32'd0);
    check("exit_wrptr", 32'(dut.wr_ptr), 32'h05);

    wr(10'h200);
    rd(8'h22);
    bus.rx_data = 10'h199;
    rst_n = 1'b0;
    #1;
    check("async_txv", 32'(bus.tx_valid), 32'd0);
    check("async_txd", 32'(bus.tx_data), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("held_txv", 32'(bus.tx_valid), 32'd0);
    check("held_wrptr", 32'(dut.wr_ptr), 32'd0);
    wr(10'h200);
    rd(8'h22);

    repeat (2) @(posedge clk);
    #1 check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
